dsp_wdata_channel: RTL

Write-data dispatcher for one master port of the AXI4 interconnect; the transmit-side counterpart of the read-data dispatcher. It buffers W beats from the master and routes each burst to exactly one slave-arbitration port. The target slave comes from an in-order queue of slave IDs that the AW channel dispatcher pushes on each accepted AW. Bursts are forwarded strictly in AW order, and a burst is never split across slaves.

---
 rtl/dsp_wdata_channel_pkg.sv | 15 +
 rtl/dsp_wdata_channel_fifo.sv | 53 +++++
 rtl/dsp_wdata_channel.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dsp_wdata_channel_pkg.sv
// Shared definitions for the write-data dispatcher: dispatcher states and
// the packed width of one buffered W beat.
package dsp_wdata_channel_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } dsp_wdata_state_e;

    // One buffered beat is {WDATA, WSTRB, WLAST}.
    function automatic int data_info_w(input int data_width);
        return data_width + data_width / 8 + 1;
    endfunction

endpackage

// File: rtl/dsp_wdata_channel_fifo.sv
// Show-ahead FIFO: the head entry is presented on data_o without a read.
// Writes while full and reads while empty are ignored.
module dsp_wdata_channel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    input  logic             wr_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             wr_en;
    logic             rd_en;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wr_ptr_reg == rd_ptr_reg);
    assign full_o  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign wr_en   = wr_i & ~full_o;
    assign rd_en   = rd_i & ~empty_o;
    assign data_o  = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dsp_wdata_channel.sv
// Write-data dispatcher for one master port: buffers W beats and routes each
// burst, whole and in AW order, to the slave named by the AW slave-ID queue.
module dsp_wdata_channel
    import dsp_wdata_channel_pkg::*;
#(
    parameter int SLV_AMT         = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int SLV_ID_W        = $clog2(SLV_AMT),
    parameter int DSP_WDATA_DEPTH = 16,
    parameter int DSP_AW_ID_DEPTH = 4
) (
    input  logic                           ACLK_i,
    input  logic                           ARESET_i,
    input  logic [DATA_WIDTH-1:0]          m_WDATA_i,
    input  logic [DATA_WIDTH/8-1:0]        m_WSTRB_i,
    input  logic                           m_WLAST_i,
    input  logic                           m_WVALID_i,
    output logic                           m_WREADY_o,
    input  logic [SLV_ID_W-1:0]            dsp_AW_slv_id_i,
    input  logic                           dsp_AW_push_i,
    output logic                           dsp_AW_full_o,
    output logic [DATA_WIDTH*SLV_AMT-1:0]  sa_WDATA_o,
    output logic [DATA_WIDTH/8*SLV_AMT-1:0] sa_WSTRB_o,
    output logic [SLV_AMT-1:0]             sa_WLAST_o,
    output logic [SLV_AMT-1:0]             sa_WVALID_o,
    input  logic [SLV_AMT-1:0]             sa_WREADY_i
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int INFO_W = data_info_w(DATA_WIDTH);

    logic                  rst_n;
    logic [INFO_W-1:0]     wfifo_din;
    logic [INFO_W-1:0]     wfifo_head;
    logic                  wfifo_wr;
    logic                  wfifo_rd;
    logic                  wfifo_empty;
    logic                  wfifo_full;
    logic [SLV_ID_W-1:0]   idq_head;
    logic                  idq_rd;
    logic                  idq_empty;
    logic                  idq_full;
    logic [DATA_WIDTH-1:0] head_data;
    logic [STRB_W-1:0]     head_strb;
    logic                  head_last;
    logic                  burst_valid;
    logic                  beat_hs;

    dsp_wdata_state_e      state_q;
    dsp_wdata_state_e      state_next;
    logic [SLV_ID_W-1:0]   cur_slv_q;
    logic [SLV_ID_W-1:0]   cur_slv_next;

    assign rst_n      = ~ARESET_i;
    assign m_WREADY_o = ~wfifo_full & ~ARESET_i;
    assign wfifo_wr   = m_WVALID_i & m_WREADY_o;
    assign wfifo_din  = {m_WDATA_i, m_WSTRB_i, m_WLAST_i};
    assign dsp_AW_full_o = idq_full;

    assign head_data = wfifo_head[INFO_W-1 -: DATA_WIDTH];
    assign head_strb = wfifo_head[STRB_W:1];
    assign head_last = wfifo_head[0];

    dsp_wdata_channel_fifo #(
        .WIDTH (INFO_W),
        .DEPTH (DSP_WDATA_DEPTH)
    ) fifo_wdata (
        .clk     (ACLK_i),
        .rst_n   (rst_n),
        .data_i  (wfifo_din),
        .wr_i    (wfifo_wr),
        .rd_i    (wfifo_rd),
        .data_o  (wfifo_head),
        .empty_o (wfifo_empty),
        .full_o  (wfifo_full)
    );

    dsp_wdata_channel_fifo #(
        .WIDTH (SLV_ID_W),
        .DEPTH (DSP_AW_ID_DEPTH)
    ) fifo_aw_id (
        .clk     (ACLK_i),
        .rst_n   (rst_n),
        .data_i  (dsp_AW_slv_id_i),
        .wr_i    (dsp_AW_push_i),
        .rd_i    (idq_rd),
        .data_o  (idq_head),
        .empty_o (idq_empty),
        .full_o  (idq_full)
    );

    assign burst_valid = (state_q == ST_BURST) & ~wfifo_empty;
    assign beat_hs     = burst_valid & sa_WREADY_i[cur_slv_q];
    assign wfifo_rd    = beat_hs;

    // Payload fans out to every slave; only the selected valid bit is raised.
    for (genvar gi = 0; gi < SLV_AMT; gi++) begin : g_slv
        assign sa_WDATA_o[gi*DATA_WIDTH +: DATA_WIDTH] = head_data;
        assign sa_WSTRB_o[gi*STRB_W +: STRB_W]         = head_strb;
        assign sa_WLAST_o[gi]  = head_last;
        assign sa_WVALID_o[gi] = burst_valid & (cur_slv_q == SLV_ID_W'(gi));
    end

    always_comb begin
        state_next   = state_q;
        cur_slv_next = cur_slv_q;
        idq_rd       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!idq_empty) begin
                    idq_rd       = 1'b1;
                    cur_slv_next = idq_head;
                    state_next   = ST_BURST;
                end
            end
            ST_BURST: begin
                // A queued ID lets the next burst start without a bubble.
                if (beat_hs && head_last) begin
                    if (!idq_empty) begin
                        idq_rd       = 1'b1;
                        cur_slv_next = idq_head;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            state_q   <= ST_IDLE;
            cur_slv_q <= '0;
        end else begin
            state_q   <= state_next;
            cur_slv_q <= cur_slv_next;
        end
    end

endmodule
